// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin drain of NCH first-word-fall-through FIFOs
// into a single downstream port. At most one word is delivered every two cycles.
// The SETTLE cycle after each grant gives a FIFO's empty flag, which updates
// one cycle after the pop, time to catch up before the channel is searched again.
module fifo_drain_arbiter #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           empty_i,
  input  logic [NCH*WIDTH-1:0]     data_i,
  output logic [NCH-1:0]           pop_o,
  input  logic [NCH-1:0]           enable_i,
  input  logic                     ready_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(NCH)-1:0]   ch_o,
  output logic                     ack_o,
  output logic [15:0]              count_o
);

  localparam int unsigned CW = $clog2(NCH);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   last_grant;
  logic [CW-1:0]   grant_idx;
  logic [CW-1:0]   cand;
  logic            grant_vld;
  logic            grant;
  logic [NCH-1:0]  eligible;

  assign eligible = enable_i & ~empty_i;

  // Round-robin search starting one past the previous winner, wrapping at NCH
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = CW'((32'(last_grant) + i) % NCH);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state logic: grant only from IDLE, always spend one cycle in SETTLE
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (ready_i && grant_vld) begin
          state_nxt = SETTLE;
          grant     = 1'b1;
        end
      end
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered grant outputs; data_o/ch_o hold between grants, strobes are one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_o      <= '0;
      ack_o      <= 1'b0;
      data_o     <= '0;
      ch_o       <= '0;
      count_o    <= '0;
      last_grant <= CW'(NCH - 1);
    end else if (grant) begin
      pop_o      <= NCH'(1) << grant_idx;
      ack_o      <= 1'b1;
      data_o     <= data_i[grant_idx*WIDTH +: WIDTH];
      ch_o       <= grant_idx;
      count_o    <= count_o + 16'd1;
      last_grant <= grant_idx;
    end else begin
      pop_o <= '0;
      ack_o <= 1'b0;
    end
  end

endmodule
